mix_columns_ctrl: RTL and testbench

MIX_COLUMNS_CTRL -- requirements
Module: mix_columns_ctrl

---
 rtl/mix_columns_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mix_columns_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mix_columns_ctrl.sv
// rtl/mix_columns_ctrl.sv - AES (Inv)MixColumns engine, one column per cycle
// Optional macro: MIX_COLUMNS_DEC_EN enables the InvMixColumns path (dec input).
module mix_columns_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         dec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [1:0]   col_q;
    logic [127:0] work_q;
    logic [127:0] work_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_enc(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_DEC_EN
    logic dec_q;

    // Multiplies by 09, 0B, 0D, 0E built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] mix_dec(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        a[0] = c[31:24];
        a[1] = c[23:16];
        a[2] = c[15:8];
        a[3] = c[7:0];
        for (int i = 0; i < 4; i++) begin
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign col_out = dec_q ? mix_dec(col_in) : mix_enc(col_in);
`else
    logic unused_dec;

    assign unused_dec = dec;
    assign col_out    = mix_enc(col_in);
`endif

    always_comb begin
        col_in = 32'h0;
        work_d = work_q;
        case (col_q)
            2'd0: col_in = work_q[127:96];
            2'd1: col_in = work_q[95:64];
            2'd2: col_in = work_q[63:32];
            2'd3: col_in = work_q[31:0];
            default: col_in = 32'h0;
        endcase
        case (col_q)
            2'd0: work_d[127:96] = col_out;
            2'd1: work_d[95:64]  = col_out;
            2'd2: work_d[63:32]  = col_out;
            2'd3: work_d[31:0]   = col_out;
            default: work_d = work_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= 2'd0;
            work_q <= 128'h0;
`ifdef MIX_COLUMNS_DEC_EN
            dec_q  <= 1'b0;
`endif
        end else if (state_q == IDLE && in_valid) begin
            col_q  <= 2'd0;
            work_q <= state_in;
`ifdef MIX_COLUMNS_DEC_EN
            dec_q  <= dec;
`endif
        end else if (state_q == BUSY) begin
            col_q  <= col_q + 2'd1;
            work_q <= work_d;
        end
    end

    assign state_out = out_valid ? work_q : 128'h0;

endmodule

// File: tb/tb_mix_columns_ctrl.sv
// tb/tb_mix_columns_ctrl.sv - directed-vector bench for mix_columns_ctrl
module tb_mix_columns_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         dec;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] VEC_IN  = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] VEC_ENC = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] ALL_C6  = {16{8'hc6}};
    localparam logic [127:0] ALL_01  = {16{8'h01}};

    mix_columns_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .dec       (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one block, toggles dec after acceptance, and returns the result.
    task automatic run_block(input string tag, input logic [127:0] d, input logic dc,
                             output logic [127:0] res);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        state_in = d;
        dec      = dc;
        @(negedge clk);
        in_valid = 1'b0;
        dec      = ~dc;
        state_in = ~d;
        n = 0;
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_cycles"}, 128'(n), 128'd4);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd1);
        res       = state_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_back_idle"}, {126'd0, in_ready, out_valid}, 128'b10);
    endtask

    logic [127:0] res;
    logic [127:0] held;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        state_in  = 128'h0;
        dec       = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_state_out", state_out, 128'h0);

        run_block("enc_vec", VEC_IN, 1'b0, res);
        check("enc_vec_result", res, VEC_ENC);

`ifdef MIX_COLUMNS_DEC_EN
        run_block("dec_vec", VEC_ENC, 1'b1, res);
        check("dec_vec_result", res, VEC_IN);
        run_block("dec_c6", ALL_C6, 1'b1, res);
        check("dec_c6_result", res, ALL_C6);
        run_block("dec_01", ALL_01, 1'b1, res);
        check("dec_01_result", res, ALL_01);
`else
        run_block("nodec_vec", VEC_IN, 1'b1, res);
        check("nodec_vec_result", res, VEC_ENC);
`endif
        run_block("enc_c6", ALL_C6, 1'b0, res);
        check("enc_c6_result", res, ALL_C6);
        run_block("enc_01", ALL_01, 1'b0, res);
        check("enc_01_result", res, ALL_01);

        // Backpressure: hold DONE for 10 cycles with a stray in_valid pulse.
        in_valid = 1'b1;
        state_in = VEC_IN;
        dec      = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("bp_out_valid", 128'(out_valid), 128'd1);
        held = state_out;
        check("bp_first", held, VEC_ENC);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            state_in = ALL_01;
            @(negedge clk);
            check($sformatf("bp_stable_%0d", i), state_out, held);
            check($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", {126'd0, in_ready, out_valid}, 128'b10);
        @(negedge clk);
        check("bp_not_captured", {126'd0, busy, out_valid}, 128'b00);

        // Reset in the second BUSY cycle aborts the block.
        in_valid = 1'b1;
        state_in = VEC_IN;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_state_out", state_out, 128'h0);
        run_block("after_abort", VEC_IN, 1'b0, res);
        check("after_abort_result", res, VEC_ENC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
